// File: rtl/node_injector.sv
// Node injector: turns packet descriptors plus body payloads into router flits, with round-robin VC choice.
// Optional statistics counters (pkt/flit/stall) are enabled by defining NODE_INJECTOR_STATS_EN.

package noc_params;
  localparam int DEST_ADDR_SIZE_X  = 2;
  localparam int DEST_ADDR_SIZE_Y  = 2;
  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module node_injector #(
  parameter  int MAX_PKT_LEN = 16,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     pkt_valid_i,
  output logic                                     pkt_ready_o,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [LEN_W-1:0]                         pkt_len_i,
  input  logic [noc_params::HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic                                     pl_valid_i,
  output logic                                     pl_ready_o,
  input  logic [noc_params::FLIT_DATA_SIZE-1:0]    pl_data_i,
  output noc_params::flit_t                        data_o,
  output logic                                     is_valid_o,
  input  logic [noc_params::VC_NUM-1:0]            is_on_off_i,
  input  logic [noc_params::VC_NUM-1:0]            is_allocatable_i
`ifdef NODE_INJECTOR_STATS_EN
  ,
  output logic [15:0]                              pkt_cnt_o,
  output logic [15:0]                              flit_cnt_o,
  output logic [15:0]                              stall_cnt_o
`endif
);

  localparam int VC_NUM  = noc_params::VC_NUM;
  localparam int VC_SIZE = noc_params::VC_SIZE;

  typedef enum logic [1:0] {IDLE, VC_SEL, BODY} state_e;

  state_e                                   state_q, state_d;
  logic [VC_SIZE-1:0]                       rr_q, rr_d;
  logic [VC_SIZE-1:0]                       vc_q, vc_d;
  logic [LEN_W-1:0]                         len_q, len_d;
  logic [noc_params::DEST_ADDR_SIZE_X-1:0]  x_q, x_d;
  logic [noc_params::DEST_ADDR_SIZE_Y-1:0]  y_q, y_d;
  logic [noc_params::HEAD_PAYLOAD_SIZE-1:0] hpl_q, hpl_d;
  noc_params::flit_t                        data_q, data_d;
  logic                                     valid_q, valid_d;

  logic               found;
  logic [VC_SIZE-1:0] pick;
  logic [VC_SIZE-1:0] cand;
  logic [LEN_W-1:0]   len_clamped;
  logic               pl_fire;

  // Search order starts one past the last used VC and wraps, so each VC gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= VC_NUM; i++) begin
      cand = VC_SIZE'((32'(rr_q) + i) % VC_NUM);
      if (!found && is_allocatable_i[cand] && is_on_off_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    if (pkt_len_i == '0)                      len_clamped = LEN_W'(1);
    else if (pkt_len_i > LEN_W'(MAX_PKT_LEN)) len_clamped = LEN_W'(MAX_PKT_LEN);
    else                                      len_clamped = pkt_len_i;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    vc_d        = vc_q;
    len_d       = len_q;
    x_d         = x_q;
    y_d         = y_q;
    hpl_d       = hpl_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    pkt_ready_o = 1'b0;
    pl_ready_o  = 1'b0;
    pl_fire     = 1'b0;
    unique case (state_q)
      IDLE: begin
        pkt_ready_o = 1'b1;
        if (pkt_valid_i) begin
          x_d     = pkt_x_dest_i;
          y_d     = pkt_y_dest_i;
          hpl_d   = pkt_head_pl_i;
          len_d   = len_clamped;
          state_d = VC_SEL;
        end
      end
      VC_SEL: begin
        if (found) begin
          data_d                        = '0;
          data_d.flit_label             = (len_q == LEN_W'(1)) ? noc_params::HEADTAIL : noc_params::HEAD;
          data_d.vc_id                  = pick;
          data_d.data.head_data.x_dest  = x_q;
          data_d.data.head_data.y_dest  = y_q;
          data_d.data.head_data.head_pl = hpl_q;
          valid_d = 1'b1;
          rr_d    = pick;
          vc_d    = pick;
          len_d   = len_q - LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? IDLE : BODY;
        end
      end
      BODY: begin
        pl_ready_o = is_on_off_i[vc_q];
        pl_fire    = pl_valid_i && is_on_off_i[vc_q];
        if (pl_fire) begin
          data_d            = '0;
          data_d.flit_label = (len_q == LEN_W'(1)) ? noc_params::TAIL : noc_params::BODY;
          data_d.vc_id      = vc_q;
          data_d.data.bt_pl = pl_data_i;
          valid_d = 1'b1;
          len_d   = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pkt_ready_o = 1'b0;
      pl_ready_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      vc_q    <= '0;
      len_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hpl_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      vc_q    <= vc_d;
      len_q   <= len_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hpl_q   <= hpl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o     = data_q;
  assign is_valid_o = valid_q;

`ifdef NODE_INJECTOR_STATS_EN
  logic [15:0] pkt_cnt_q, flit_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (valid_d) flit_cnt_q <= flit_cnt_q + 16'd1;
      if (valid_d && (data_d.flit_label == noc_params::TAIL ||
                      data_d.flit_label == noc_params::HEADTAIL))
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (state_q == BODY && pl_valid_i && !pl_ready_o) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign flit_cnt_o  = flit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_node_injector.sv
// Randomized bench for node_injector against a packet-level reference model; also checks the optional
// NODE_INJECTOR_STATS_EN counters when that macro is defined.
module tb_node_injector;
  import noc_params::*;

  localparam int MAXL  = 16;
  localparam int LEN_W = $clog2(MAXL + 1);

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         pkt_valid_i = 1'b0;
  logic                         pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i = '0;
  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i = '0;
  logic [LEN_W-1:0]             pkt_len_i = '0;
  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i = '0;
  logic                         pl_valid_i = 1'b0;
  logic                         pl_ready_o;
  logic [FLIT_DATA_SIZE-1:0]    pl_data_i = '0;
  flit_t                        data_o;
  logic                         is_valid_o;
  logic [VC_NUM-1:0]            is_on_off_i = '1;
  logic [VC_NUM-1:0]            is_allocatable_i = '1;
`ifdef NODE_INJECTOR_STATS_EN
  logic [15:0] pkt_cnt_o, flit_cnt_o, stall_cnt_o;
`endif

  node_injector #(.MAX_PKT_LEN(MAXL)) dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .pkt_x_dest_i     (pkt_x_dest_i),
    .pkt_y_dest_i     (pkt_y_dest_i),
    .pkt_len_i        (pkt_len_i),
    .pkt_head_pl_i    (pkt_head_pl_i),
    .pl_valid_i       (pl_valid_i),
    .pl_ready_o       (pl_ready_o),
    .pl_data_i        (pl_data_i),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i)
`ifdef NODE_INJECTOR_STATS_EN
    ,
    .pkt_cnt_o        (pkt_cnt_o),
    .flit_cnt_o       (flit_cnt_o),
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the packet in flight is "accepted", then "has a VC", with m_left flits still owed.
  bit    m_busy = 0, m_hasvc = 0;
  int    m_vc = 0, m_last = 0, m_left = 0;
  logic [DEST_ADDR_SIZE_X-1:0]  m_x;
  logic [DEST_ADDR_SIZE_Y-1:0]  m_y;
  logic [HEAD_PAYLOAD_SIZE-1:0] m_hpl;
  flit_t m_data = '0;
  bit    m_valid = 0;
  int    m_pkts = 0, m_flits = 0, m_stalls = 0;

  task automatic model_update();
    flit_t f;
    int    len;
    bit    got_vc;
    m_valid = 0;
    if (rst) begin
      m_busy = 0; m_hasvc = 0; m_last = 0; m_data = '0;
      m_pkts = 0; m_flits = 0; m_stalls = 0;
      return;
    end
    if (!m_busy) begin
      if (pkt_valid_i) begin
        len = int'(pkt_len_i);
        if (len == 0) len = 1;
        if (len > MAXL) len = MAXL;
        m_busy = 1; m_hasvc = 0; m_left = len;
        m_x = pkt_x_dest_i; m_y = pkt_y_dest_i; m_hpl = pkt_head_pl_i;
      end
    end else if (!m_hasvc) begin
      got_vc = 0;
      for (int k = 1; k <= VC_NUM; k++) begin
        int v;
        v = (m_last + k) % VC_NUM;
        if (!got_vc && is_allocatable_i[v] && is_on_off_i[v]) begin
          got_vc = 1; m_vc = v;
        end
      end
      if (got_vc) begin
        f = '0;
        f.flit_label = (m_left == 1) ? HEADTAIL : HEAD;
        f.vc_id      = VC_SIZE'(m_vc);
        f.data.head_data.x_dest  = m_x;
        f.data.head_data.y_dest  = m_y;
        f.data.head_data.head_pl = m_hpl;
        m_data = f; m_valid = 1; m_hasvc = 1; m_last = m_vc;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      if (pl_valid_i && !is_on_off_i[m_vc]) m_stalls = (m_stalls + 1) % 65536;
      if (pl_valid_i && is_on_off_i[m_vc]) begin
        m_left--;
        f = '0;
        f.flit_label = (m_left == 0) ? TAIL : BODY;
        f.vc_id      = VC_SIZE'(m_vc);
        f.data.bt_pl = pl_data_i;
        m_data = f; m_valid = 1;
        if (m_left == 0) m_busy = 0;
      end
    end
    if (m_valid) begin
      m_flits = (m_flits + 1) % 65536;
      if (m_data.flit_label == TAIL || m_data.flit_label == HEADTAIL) m_pkts = (m_pkts + 1) % 65536;
    end
  endtask

  // One clock: inputs are already set at the falling edge; readies checked now, registered outputs after the edge.
  task automatic step();
    #1;
    check_eq("pkt_ready", pkt_ready_o, !rst && !m_busy);
    check_eq("pl_ready", pl_ready_o, !rst && m_busy && m_hasvc && is_on_off_i[m_vc]);
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_eq("is_valid", is_valid_o, m_valid);
    check_eq("data", data_o, m_data);
`ifdef NODE_INJECTOR_STATS_EN
    check_eq("pkt_cnt", pkt_cnt_o, m_pkts);
    check_eq("flit_cnt", flit_cnt_o, m_flits);
    check_eq("stall_cnt", stall_cnt_o, m_stalls);
`endif
    pl_data_i = FLIT_DATA_SIZE'($urandom);
  endtask

  task automatic send_desc(input int len);
    pkt_valid_i   = 1'b1;
    pkt_len_i     = LEN_W'(len);
    pkt_x_dest_i  = DEST_ADDR_SIZE_X'($urandom);
    pkt_y_dest_i  = DEST_ADDR_SIZE_Y'($urandom);
    pkt_head_pl_i = HEAD_PAYLOAD_SIZE'($urandom);
    step();
    pkt_valid_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    #1 check_eq("ready_after_rst", pkt_ready_o, 1'b1);
    step();

    // single-flit packet from rr=0 goes out on VC1
    send_desc(1);
    step();
    check_eq("headtail_vc", data_o.vc_id, 1);
    check_eq("headtail_lbl", data_o.flit_label, HEADTAIL);
    step();

    // four-flit packet with payload always available
    pl_valid_i = 1'b1;
    send_desc(4);
    repeat (6) step();

    // no allocatable VC for five cycles, then VC0 only
    is_allocatable_i = '0;
    send_desc(2);
    repeat (5) step();
    is_allocatable_i = VC_NUM'(1);
    step();
    check_eq("alloc_vc0_valid", is_valid_o, 1'b1);
    check_eq("alloc_vc0_id", data_o.vc_id, 0);
    is_allocatable_i = '1;
    repeat (3) step();

    // locked VC switched off for three cycles after the head
    send_desc(3);
    step();
    is_on_off_i = '1;
    is_on_off_i[m_vc] = 1'b0;
    repeat (3) step();
    is_on_off_i = '1;
    repeat (4) step();

    // reset after two flits of a five-flit packet, then a clean packet
    send_desc(5);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_desc(2);
    repeat (4) step();

    // length clamping at both ends
    send_desc(0);
    repeat (3) step();
    send_desc(MAXL + 1);
    repeat (MAXL + 3) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      pkt_valid_i = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) != 0) pkt_len_i = LEN_W'($urandom_range(1, 5));
      else                           pkt_len_i = LEN_W'($urandom_range(0, MAXL + 1));
      pkt_x_dest_i  = DEST_ADDR_SIZE_X'($urandom);
      pkt_y_dest_i  = DEST_ADDR_SIZE_Y'($urandom);
      pkt_head_pl_i = HEAD_PAYLOAD_SIZE'($urandom);
      pl_valid_i    = $urandom_range(0, 3) != 0;
      is_allocatable_i = VC_NUM'($urandom);
      for (int b = 0; b < VC_NUM; b++) is_on_off_i[b] = $urandom_range(0, 7) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
